// File: rtl/dist_hist_gen.sv
// Population distribution histogram: counts samples below median +/- k*MAD
// thresholds and streams |count - target| per bin on a ready/valid port.
module dist_hist_gen #(
  parameter int unsigned POPSIZE = 100,
  parameter int unsigned DW      = 8,
  parameter int unsigned FW      = 8,
  parameter int unsigned NUM_K   = 3,
  parameter int unsigned CW      = $clog2(POPSIZE + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [DW-1:0]               median,
  input  logic [DW+FW-1:0]            mad,
  input  logic [CW-1:0]               target,
  output logic                        rd_en,
  output logic [$clog2(POPSIZE)-1:0]  rd_addr,
  input  logic                        rd_vld,
  input  logic [DW-1:0]               rd_data,
  output logic                        out_vld,
  input  logic                        out_rdy,
  output logic [$clog2(2*NUM_K)-1:0]  out_idx,
  output logic [CW-1:0]               out_data,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned AW   = $clog2(POPSIZE);
  localparam int unsigned BINS = 2 * NUM_K;
  localparam int unsigned IW   = $clog2(BINS);
  localparam int unsigned TW   = DW + FW + $clog2(NUM_K) + 1;

  typedef enum logic [1:0] {IDLE, READ, SEND} state_t;
  state_t state_q, state_d;

  logic [DW-1:0]    med_q;
  logic [DW+FW-1:0] mad_q;
  logic [CW-1:0]    tgt_q;
  logic [TW-1:0]    thr_q [BINS];
  logic [TW-1:0]    thr_d [BINS];
  logic [TW-1:0]    kmad  [BINS];
  logic [CW-1:0]    cnt_q [BINS];
  logic [CW-1:0]    resp_q;
  logic             thr_load_q;
  logic [IW-1:0]    idx_q;
  logic             rd_en_q;
  logic [AW-1:0]    rd_addr_q;
  logic             done_q;

  logic             start_acc, resp_acc, last_resp, last_bin, hs;
  logic [TW-1:0]    med_fx, samp_fx;
  logic [CW-1:0]    cur_cnt, diff;

  assign start_acc = (state_q == IDLE) && start && !abort;
  assign resp_acc  = (state_q == READ) && rd_vld && (resp_q < CW'(POPSIZE));
  assign last_resp = resp_acc && (resp_q == CW'(POPSIZE - 1));
  assign last_bin  = (idx_q == IW'(BINS - 1));
  assign hs        = (state_q == SEND) && out_rdy;

  assign med_fx  = TW'(med_q) << FW;
  assign samp_fx = TW'(rd_data) << FW;

  // Even bins add k*MAD, odd bins subtract it with a floor at zero
  always_comb begin
    for (int unsigned j = 0; j < BINS; j++) begin
      kmad[j] = TW'(j / 2 + 1) * TW'(mad_q);
      if ((j % 2) == 0)
        thr_d[j] = med_fx + kmad[j];
      else if (kmad[j] > med_fx)
        thr_d[j] = '0;
      else
        thr_d[j] = med_fx - kmad[j];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_acc) state_d = READ;
      READ: if (last_resp) state_d = SEND;
      SEND: if (hs && last_bin) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      med_q      <= '0;
      mad_q      <= '0;
      tgt_q      <= '0;
      resp_q     <= '0;
      thr_load_q <= 1'b0;
      idx_q      <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      done_q     <= 1'b0;
      for (int unsigned j = 0; j < BINS; j++) begin
        thr_q[j] <= '0;
        cnt_q[j] <= '0;
      end
    end else begin
      thr_load_q <= start_acc;
      done_q     <= hs && last_bin && !abort;
      if (thr_load_q) begin
        for (int unsigned j = 0; j < BINS; j++) thr_q[j] <= thr_d[j];
      end

      if (start_acc) begin
        med_q  <= median;
        mad_q  <= mad;
        tgt_q  <= target;
        resp_q <= '0;
        idx_q  <= '0;
        for (int unsigned j = 0; j < BINS; j++) cnt_q[j] <= '0;
      end else if (resp_acc) begin
        resp_q <= resp_q + CW'(1);
        for (int unsigned j = 0; j < BINS; j++) begin
          if (samp_fx < thr_q[j]) cnt_q[j] <= cnt_q[j] + CW'(1);
        end
      end else if (hs && !abort) begin
        idx_q <= last_bin ? '0 : idx_q + IW'(1);
      end

      // Address issue runs independently of response arrival
      if (abort) begin
        rd_en_q <= 1'b0;
      end else if (start_acc) begin
        rd_en_q   <= 1'b1;
        rd_addr_q <= '0;
      end else if (rd_en_q) begin
        if (rd_addr_q == AW'(POPSIZE - 1)) rd_en_q <= 1'b0;
        else                                rd_addr_q <= rd_addr_q + AW'(1);
      end
    end
  end

  assign cur_cnt = cnt_q[idx_q];
  assign diff    = (cur_cnt >= tgt_q) ? (cur_cnt - tgt_q) : (tgt_q - cur_cnt);

  assign rd_en    = rd_en_q;
  assign rd_addr  = rd_addr_q;
  assign out_vld  = (state_q == SEND);
  assign out_idx  = idx_q;
  assign out_data = (state_q == SEND) ? diff : '0;
  assign out_last = (state_q == SEND) && last_bin;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

endmodule
